uart_tx_framer: RTL

//  Parametrised UART transmit framer; successor to the fixed 8-bit parity generator.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_parity.sv | 41 ++++
 rtl/uart_tx_framer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Parity modes, framer state encoding and legal data widths.
package uart_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_parity.sv
// Combinational parity bit for a UART data word.
// valid is low when the mode selects no parity bit (including codes 5..7).
module uart_parity
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        mode,
    output logic              par,
    output logic              valid
);

    always_comb begin
        par   = 1'b0;
        valid = 1'b0;
        unique case (mode)
            PAR_EVEN: begin
                par   = ^data;
                valid = 1'b1;
            end
            PAR_ODD: begin
                par   = ~^data;
                valid = 1'b1;
            end
            PAR_MARK: begin
                par   = 1'b1;
                valid = 1'b1;
            end
            PAR_SPACE: begin
                par   = 1'b0;
                valid = 1'b1;
            end
            default: begin
                par   = 1'b0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, DATA_W bits LSB first, optional parity, 1/2 stops.
// All frame settings are captured on accept so the frame ignores later input changes.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [2:0]        par_mode,
    input  logic              stop2,
    input  logic [DIV_W-1:0]  baud_div,
    output logic              txd,
    output logic              busy
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  baud_cnt;
    logic [DIV_W-1:0]  p_m1;
    logic [BW-1:0]     bit_cnt;
    logic              par_q;
    logic              par_en_q;
    logic              stop2_q;
    logic              par_bit;
    logic              par_en;
    logic              bit_end;

    uart_parity #(
        .DATA_W(DATA_W)
    ) u_parity (
        .data (tx_data),
        .mode (par_mode),
        .par  (par_bit),
        .valid(par_en)
    );

    // A divider of 0 or 1 both give one clock per bit.
    assign p_m1    = (div_q > DIV_W'(1)) ? div_q - DIV_W'(1) : '0;
    assign bit_end = (baud_cnt == p_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shift    <= '0;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            if (state != ST_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + DIV_W'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (tx_valid && tx_ready) begin
                        shift    <= tx_data;
                        div_q    <= baud_div;
                        par_q    <= par_bit;
                        par_en_q <= par_en;
                        stop2_q  <= stop2;
                        txd      <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        txd   <= shift[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (par_en_q) begin
                                txd   <= par_q;
                                state <= ST_PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            txd     <= shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        // bit_cnt tracks the first of two stop bits.
                        if (stop2_q && bit_cnt == '0) begin
                            bit_cnt <= BW'(1);
                        end else begin
                            bit_cnt  <= '0;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
